// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard controller slice.
// Prefix bytes, FSM states and the packed key-event record.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ps2_evt_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PREFIX_EXT) || (b == PS2_PREFIX_BRK);
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational scan-code set 2 to lowercase ASCII map.
// Covers letters, digits, space, enter and backspace; everything else maps to 0x00.
module ps2_scan2ascii (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  // Lookup table
  always_comb begin
    case (code_i)
      8'h1C: ascii_o = 8'h61; 8'h32: ascii_o = 8'h62; 8'h21: ascii_o = 8'h63;
      8'h23: ascii_o = 8'h64; 8'h24: ascii_o = 8'h65; 8'h2B: ascii_o = 8'h66;
      8'h34: ascii_o = 8'h67; 8'h33: ascii_o = 8'h68; 8'h43: ascii_o = 8'h69;
      8'h3B: ascii_o = 8'h6A; 8'h42: ascii_o = 8'h6B; 8'h4B: ascii_o = 8'h6C;
      8'h3A: ascii_o = 8'h6D; 8'h31: ascii_o = 8'h6E; 8'h44: ascii_o = 8'h6F;
      8'h4D: ascii_o = 8'h70; 8'h15: ascii_o = 8'h71; 8'h2D: ascii_o = 8'h72;
      8'h1B: ascii_o = 8'h73; 8'h2C: ascii_o = 8'h74; 8'h3C: ascii_o = 8'h75;
      8'h2A: ascii_o = 8'h76; 8'h1D: ascii_o = 8'h77; 8'h22: ascii_o = 8'h78;
      8'h35: ascii_o = 8'h79; 8'h1A: ascii_o = 8'h7A;
      8'h45: ascii_o = 8'h30; 8'h16: ascii_o = 8'h31; 8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33; 8'h25: ascii_o = 8'h34; 8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36; 8'h3D: ascii_o = 8'h37; 8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      8'h29: ascii_o = 8'h20; 8'h5A: ascii_o = 8'h0D; 8'h66: ascii_o = 8'h08;
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Drains the PS/2 receiver FIFO, folds E0/F0 prefixes into key events,
// tracks the held key for typematic detection and offers events over valid/ready.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kb_ready,
  input  logic [7:0]       kb_data,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic [7:0]       evt_ascii,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_err,
  input  logic             ovf_clr
);

  ps2_state_e       state_q, state_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic [7:0]       byte_q;
  logic             ext_f_q, ext_f_d, brk_f_q, brk_f_d;
  ps2_evt_t         evt_q, evt_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       ascii_q, ascii_d;
  logic             held_valid_q, held_valid_d, held_ext_q, held_ext_d;
  logic [7:0]       held_code_q, held_code_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             ovf_err_q, ovf_err_d;
  logic [7:0]       ascii_s;
  logic             key_match_s;

  ps2_scan2ascii u_map (
    .code_i  (byte_q),
    .ascii_o (ascii_s)
  );

  assign key_match_s = held_valid_q && (held_code_q == byte_q) && (held_ext_q == ext_f_q);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: only fetch a byte when no event is pending
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (kb_ready && !evt_valid_q) state_d = ST_POP;
        else                          state_d = ST_IDLE;
      end
      ST_POP:    state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output: pop strobe registered so it is low exactly during POP
  always_comb begin
    if (state_d == ST_POP) nextdata_n_d = 1'b0;
    else                   nextdata_n_d = 1'b1;
  end

  // Decode, held-key tracking and event register next state
  always_comb begin
    ext_f_d      = ext_f_q;
    brk_f_d      = brk_f_q;
    evt_d        = evt_q;
    ascii_d      = ascii_q;
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    press_cnt_d  = press_cnt_q;
    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
    else                          evt_valid_d = evt_valid_q;

    if (state_q == ST_SETTLE) begin
      if (byte_q == PS2_PREFIX_EXT) begin
        ext_f_d = 1'b1;
      end else if (byte_q == PS2_PREFIX_BRK) begin
        brk_f_d = 1'b1;
      end else begin
        evt_d.code  = byte_q;
        evt_d.ext   = ext_f_q;
        evt_d.brk   = brk_f_q;
        evt_d.rep   = !brk_f_q && key_match_s;
        ascii_d     = ext_f_q ? 8'h00 : ascii_s;
        evt_valid_d = 1'b1;
        ext_f_d     = 1'b0;
        brk_f_d     = 1'b0;
        if (brk_f_q) begin
          if (key_match_s) held_valid_d = 1'b0;
          else             held_valid_d = held_valid_q;
        end else if (!key_match_s) begin
          held_valid_d = 1'b1;
          held_code_d  = byte_q;
          held_ext_d   = ext_f_q;
          press_cnt_d  = press_cnt_q + CNT_W'(1);
        end else begin
          held_valid_d = held_valid_q;
        end
      end
    end else begin
      evt_d = evt_q;
    end

    // Overflow corrupts the byte stream, so any half-built prefix is dropped
    if (kb_overflow) begin
      ext_f_d = 1'b0;
      brk_f_d = 1'b0;
    end else begin
      ext_f_d = ext_f_d;
    end

    if (kb_overflow)  ovf_err_d = 1'b1;
    else if (ovf_clr) ovf_err_d = 1'b0;
    else              ovf_err_d = ovf_err_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nextdata_n_q <= 1'b1;
      byte_q       <= 8'h00;
      ext_f_q      <= 1'b0;
      brk_f_q      <= 1'b0;
      evt_q        <= '0;
      evt_valid_q  <= 1'b0;
      ascii_q      <= 8'h00;
      held_valid_q <= 1'b0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      press_cnt_q  <= '0;
      ovf_err_q    <= 1'b0;
    end else begin
      nextdata_n_q <= nextdata_n_d;
      if (state_q == ST_POP) byte_q <= kb_data;
      ext_f_q      <= ext_f_d;
      brk_f_q      <= brk_f_d;
      evt_q        <= evt_d;
      evt_valid_q  <= evt_valid_d;
      ascii_q      <= ascii_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      press_cnt_q  <= press_cnt_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign kb_nextdata_n = nextdata_n_q;
  assign evt_valid     = evt_valid_q;
  assign evt_code      = evt_q.code;
  assign evt_ext       = evt_q.ext;
  assign evt_break     = evt_q.brk;
  assign evt_repeat    = evt_q.rep;
  assign evt_ascii     = ascii_q;
  assign held_valid    = held_valid_q;
  assign held_code     = held_code_q;
  assign held_ext      = held_ext_q;
  assign press_cnt     = press_cnt_q;
  assign ovf_err       = ovf_err_q;

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Controller between the PS/2 receiver FIFO (`ps2_keyboard`) and its consumer. It drains scan-code bytes through the receiver's `ready`/`nextdata_n` pop handshake and assembles E0/F0 prefix sequences into single key events. It tracks the currently held key to separate fresh presses from typematic repeats. Events go to the consumer over a valid/ready port with ASCII translation.

## Interface
- `CNT_W`, default 16: width of the press counter.
- `clk  in  1`: system clock; same clock as `ps2_keyboard`.
- `rst  in  1`: reset, asynchronous, active-low.
- `kb_ready  in  1`: receiver FIFO non-empty.
- `kb_data  in  8`: receiver FIFO head byte, valid while `kb_ready`=1.
- `kb_overflow  in  1`: receiver FIFO overflow flag.
- `kb_nextdata_n  out  1`: active-low pop strobe to receiver, one cycle per byte.
- `evt_valid  out  1`: key event available.
- `evt_ready  in  1`: consumer accepts the event when `evt_valid`&`evt_ready`.
- `evt_code  out  8`: final scan code, without prefixes.
- `evt_ext  out  1`: E0 prefix was seen.
- `evt_break  out  1`: release event (F0 prefix was seen).
- `evt_repeat  out  1`: make of the already-held key (typematic).
- `evt_ascii  out  8`: lowercase ASCII for non-ext makes/breaks; 0x00 if unmapped or ext.
- `held_valid  out  1`, `held_code  out  8`, `held_ext  out  1`: currently held key.
- `press_cnt  out  CNT_W`: count of fresh presses; wraps.
- `ovf_err  out  1`: sticky; set when `kb_overflow` is seen.
- `ovf_clr  in  1`: clears `ovf_err`.

## Operation
- FSM states:
  - IDLE: go to POP when `kb_ready` and no pending event (`evt_valid`=0).
  - POP: drive `kb_nextdata_n`=0, latch `kb_data` into `byte_q`, go to SETTLE.
  - SETTLE: one cycle for the receiver read pointer to update; decode `byte_q`; go to IDLE.
- Decode of `byte_q`:
  - 0xE0: set `ext_f`.
  - 0xF0: set `brk_f`.
  - Any other byte: form an event from {byte, `ext_f`, `brk_f`}, then clear both flags.
- Make (`brk_f`=0):
  - Key equal to held {code, ext}: `evt_repeat`=1; counter unchanged.
  - Otherwise: `evt_repeat`=0; held becomes this key; `press_cnt`++.
- Break (`brk_f`=1):
  - Key matches the held key: `held_valid` cleared.
  - Any other key: held state unchanged.
  - Break always produces an event with `evt_repeat`=0.
- Event register: loaded in SETTLE; `evt_*` stay stable while `evt_valid`=1 and `evt_ready`=0.
- Backpressure: no pops while an event is pending; bytes accumulate in the receiver FIFO.
- Overflow: `kb_overflow`=1 in any cycle sets `ovf_err` and clears `ext_f`/`brk_f`. The event register is untouched.
- Simultaneous `ovf_clr` and `kb_overflow`: set wins.
- Bytes 0xE1 and 0xAA are treated as ordinary codes; the consumer filters them.

## Timing
- Reset values:
  - `kb_nextdata_n`=1.
  - `evt_valid`=0; `evt_*`=0.
  - `held_*`=0, `press_cnt`=0, `ovf_err`=0.
  - FSM in IDLE; `ext_f`=`brk_f`=0.
- Reset asserted mid-sequence: partial prefixes are discarded.
- Byte throughput: one byte per 3 cycles maximum (IDLE→POP→SETTLE).
- Latency: `kb_ready` rise → `evt_valid`=1 three cycles later for an unprefixed byte.
- `evt_valid` falls the cycle after the handshake. The earliest next event follows 3 cycles later.
- All outputs are registered; `kb_nextdata_n` is never low for two consecutive cycles.

## Structure
- Package `ps2_pkg`:
  - Constants `PS2_PREFIX_EXT`=8'hE0 and `PS2_PREFIX_BRK`=8'hF0.
  - FSM state enum.
  - Packed event struct {code, ext, brk, rep}.
- Sub-module `ps2_scan2ascii`: combinational set-2 scan code → ASCII map. It covers letters, digits, space, enter and backspace.

## Test plan
- Byte 0x1C with `evt_ready`=1 → one event: code 0x1C, ext 0, break 0, repeat 0, ascii 0x61, `press_cnt`=1, `held_code`=0x1C.
- Sequence 1C, F0, 1C → two events. The second has break=1 and `held_valid`=0. Exactly 3 pops in total.
- 1B sent three times → events with repeat 0,1,1 and `press_cnt`=1. Then F0 1B → break, held cleared.
- E0 75 → single event: code 0x75, ext 1, ascii 0x00. Then E0 F0 75 → ext break.
- `evt_ready`=0 with 4 bytes queued → one event held stable and no `kb_nextdata_n` pulses. Release → remaining bytes drain in order.
- Assert `kb_overflow` after a lone F0 → `ovf_err`=1. The next 0x1C decodes as a make; `ovf_clr` clears the flag. Reset after E0 → the next 0x1C has ext 0.
